// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage CPU.
// Handles load-use bubbles, branches held in ID until resolved in EX,
// ID-stage jumps and mult/div busy stalls. Drives the PC write enable plus
// the IF/ID and ID/EX pipeline-register controls.
// Optional feature macro: HAZARD_PERF_EN adds saturating stall_cnt/flush_cnt.
module hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int MD_LAT       = 8,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_branch,
    input  logic              id_md_read,
    input  logic [1:0]        pc_src,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_mem_read,
    input  logic              ex_branch_resolved,
    input  logic              md_start,
    output logic              pc_write,
    output logic [1:0]        ifid_ctrl,
    output logic [1:0]        idex_ctrl,
    output logic              md_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // Pipeline-register control encodings shared with the CPU datapath
    localparam logic [1:0] IFID_FLUSH = 2'b00;
    localparam logic [1:0] IFID_WRITE = 2'b01;
    localparam logic [1:0] IFID_HOLD  = 2'b10;
    localparam logic [1:0] IDEX_FLUSH = 2'b00;
    localparam logic [1:0] IDEX_WRITE = 2'b01;

    // Mult/div countdown is wide enough to hold MD_LAT itself
    localparam int              MD_W    = $clog2(MD_LAT + 1);
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LAT);
    localparam logic [MD_W-1:0] MD_ONE  = MD_W'(1);

    // Extra stall cycles spent in LOAD_STALL after the first bubble in RUN
    localparam logic [1:0] BCNT_LOAD = 2'(LOAD_BUBBLES - 1);

    // Reject parameter values the counters cannot represent
    generate
        if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > 3) begin : g_bad_load_bubbles
            $error("hazard_ctrl: LOAD_BUBBLES must be 1..3");
        end
        if (MD_LAT < 1 || MD_LAT > 63) begin : g_bad_md_lat
            $error("hazard_ctrl: MD_LAT must be 1..63");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("hazard_ctrl: CNT_W must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_BR_WAIT    = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [1:0]      r_bcnt;
    logic [1:0]      w_bcnt_next;
    logic [MD_W-1:0] r_md_cnt;

    logic       w_load_use;
    logic       w_md_busy;
    logic       w_pc_write;
    logic [1:0] w_ifid;
    logic [1:0] w_idex;

    // A load in EX feeding a source register the ID instruction actually reads;
    // register 0 is hardwired zero so it never creates a dependency
    assign w_load_use = ex_mem_read && (ex_rt != '0) &&
                        ((id_uses_rs && (ex_rt == id_rs)) ||
                         (id_uses_rt && (ex_rt == id_rt)));

    assign w_md_busy = (r_md_cnt != '0);

    // Mult/div busy countdown; a new md_start restarts it from full latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_md_cnt <= '0;
        end else if (md_start) begin
            r_md_cnt <= MD_LOAD;
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - MD_ONE;
        end
    end

    // Next-state and control decode from the registered state and live inputs
    always_comb begin
        w_state_next = r_state;
        w_bcnt_next  = r_bcnt;
        w_pc_write   = 1'b0;
        w_ifid       = IFID_FLUSH;
        w_idex       = IDEX_FLUSH;
        case (r_state)
            ST_RUN: begin
                if (w_load_use) begin
                    // Load result not ready: freeze front end, bubble into EX.
                    // Checked first because a branch/jump operand may be the load.
                    w_pc_write = 1'b0;
                    w_ifid     = IFID_HOLD;
                    w_idex     = IDEX_FLUSH;
                    if (LOAD_BUBBLES > 1) begin
                        w_state_next = ST_LOAD_STALL;
                        w_bcnt_next  = BCNT_LOAD;
                    end
                end else if (id_md_read && w_md_busy) begin
                    // HI/LO read must wait for the mult/div unit
                    w_pc_write = 1'b0;
                    w_ifid     = IFID_HOLD;
                    w_idex     = IDEX_FLUSH;
                end else if (id_branch) begin
                    // Pass the branch to EX, kill the wrong-path fetch, wait
                    w_pc_write   = 1'b0;
                    w_ifid       = IFID_FLUSH;
                    w_idex       = IDEX_WRITE;
                    w_state_next = ST_BR_WAIT;
                end else if (pc_src != 2'b00) begin
                    // Jump resolved in ID: take the redirect, drop the fetched slot
                    w_pc_write = 1'b1;
                    w_ifid     = IFID_FLUSH;
                    w_idex     = IDEX_WRITE;
                end else begin
                    w_pc_write = 1'b1;
                    w_ifid     = IFID_WRITE;
                    w_idex     = IDEX_WRITE;
                end
            end
            ST_LOAD_STALL: begin
                // Remaining load bubbles; all other inputs are ignored here
                w_pc_write  = 1'b0;
                w_ifid      = IFID_HOLD;
                w_idex      = IDEX_FLUSH;
                w_bcnt_next = r_bcnt - 2'd1;
                if (r_bcnt <= 2'd1) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_BR_WAIT: begin
                // Pipeline drained until EX reports the branch outcome
                w_ifid = IFID_FLUSH;
                w_idex = IDEX_FLUSH;
                if (ex_branch_resolved) begin
                    w_pc_write   = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_pc_write = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_RUN;
                w_bcnt_next  = 2'd0;
            end
        endcase
    end

    // Hazard FSM state and load-bubble counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
            r_bcnt  <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_bcnt  <= w_bcnt_next;
        end
    end

    // Outputs forced to the safe idle pattern the moment reset_n drops
    always_comb begin
        pc_write  = 1'b0;
        ifid_ctrl = IFID_FLUSH;
        idex_ctrl = IDEX_FLUSH;
        md_busy   = 1'b0;
        if (reset_n) begin
            pc_write  = w_pc_write;
            ifid_ctrl = w_ifid;
            idex_ctrl = w_idex;
            md_busy   = w_md_busy;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating counts of front-end stall cycles and IF/ID flush cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!w_pc_write && (w_ifid == IFID_HOLD) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if ((w_ifid == IFID_FLUSH) && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: two instances (LOAD_BUBBLES=1/MD_LAT=8 and
// LOAD_BUBBLES=3/MD_LAT=3) share stimulus. Directed literal checks first,
// then randomized traffic checked every cycle against a behavioural model.
// Define HAZARD_PERF_EN to also check the saturating performance counters.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic       id_uses_rs = 0, id_uses_rt = 0, id_branch = 0, id_md_read = 0;
    logic [1:0] pc_src = '0;
    logic       ex_mem_read = 0, ex_branch_resolved = 0, md_start = 0;

    logic       pw0, pw1, busy0, busy1;
    logic [1:0] ifid0, ifid1, idex0, idex1;
`ifdef HAZARD_PERF_EN
    logic [15:0] sc0, fc0;
    logic [3:0]  sc1, fc1;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .LOAD_BUBBLES(1), .MD_LAT(8), .CNT_W(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
        .id_md_read(id_md_read), .pc_src(pc_src), .ex_rt(ex_rt),
        .ex_mem_read(ex_mem_read), .ex_branch_resolved(ex_branch_resolved),
        .md_start(md_start), .pc_write(pw0), .ifid_ctrl(ifid0),
        .idex_ctrl(idex0), .md_busy(busy0)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(sc0), .flush_cnt(fc0)
`endif
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_BUBBLES(3), .MD_LAT(3), .CNT_W(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
        .id_md_read(id_md_read), .pc_src(pc_src), .ex_rt(ex_rt),
        .ex_mem_read(ex_mem_read), .ex_branch_resolved(ex_branch_resolved),
        .md_start(md_start), .pc_write(pw1), .ifid_ctrl(ifid1),
        .idex_ctrl(idex1), .md_busy(busy1)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(sc1), .flush_cnt(fc1)
`endif
    );

    wire [4:0] o0 = {pw0, ifid0, idex0};
    wire [4:0] o1 = {pw1, ifid1, idex1};

    // {pc_write, ifid, idex} patterns
    localparam logic [4:0] RUNW  = 5'b1_01_01;
    localparam logic [4:0] STALL = 5'b0_10_00;
    localparam logic [4:0] BR0   = 5'b0_00_01;
    localparam logic [4:0] DRAIN = 5'b0_00_00;
    localparam logic [4:0] BRRES = 5'b1_00_00;
    localparam logic [4:0] JMP   = 5'b1_00_01;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    int cyc = 0;
    int mode[2];   // 0 run, 1 extra load bubbles pending, 2 waiting for branch
    int left[2];
    int mds[2];    // cycle of the most recent md_start
    int sc[2], fc[2];
    int lb[2]   = '{1, 3};
    int mdl[2]  = '{8, 3};
    int cmax[2] = '{65535, 15};

    initial begin
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0; left[i] = 0; mds[i] = -1000; sc[i] = 0; fc[i] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                int  e;
                bit  busy, lu;
                if (!reset_n) begin
                    mode[i] = 0; left[i] = 0; mds[i] = -1000; sc[i] = 0; fc[i] = 0;
                end
                busy = reset_n && (cyc > mds[i]) && (cyc <= mds[i] + mdl[i]);
                lu = ex_mem_read && (ex_rt != 0) &&
                     ((id_uses_rs && ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
                if (!reset_n) e = DRAIN;
                else if (mode[i] == 1) e = STALL;
                else if (mode[i] == 2) e = ex_branch_resolved ? BRRES : DRAIN;
                else if (lu) e = STALL;
                else if (id_md_read && busy) e = STALL;
                else if (id_branch) e = BR0;
                else if (pc_src != 0) e = JMP;
                else e = RUNW;

                chk($sformatf("model%0d_ctrl_c%0d", i, cyc), (i == 0) ? o0 : o1, e);
                chk($sformatf("model%0d_busy_c%0d", i, cyc), (i == 0) ? busy0 : busy1, busy);
`ifdef HAZARD_PERF_EN
                chk($sformatf("model%0d_stallcnt_c%0d", i, cyc), (i == 0) ? sc0 : sc1, sc[i]);
                chk($sformatf("model%0d_flushcnt_c%0d", i, cyc), (i == 0) ? fc0 : fc1, fc[i]);
`endif
                if (reset_n) begin
                    // state for the next cycle
                    if (mode[i] == 1) begin
                        left[i]--;
                        if (left[i] == 0) mode[i] = 0;
                    end else if (mode[i] == 2) begin
                        if (ex_branch_resolved) mode[i] = 0;
                    end else if (lu) begin
                        if (lb[i] > 1) begin mode[i] = 1; left[i] = lb[i] - 1; end
                    end else if (!(id_md_read && busy) && id_branch) begin
                        mode[i] = 2;
                    end
                    if (md_start) mds[i] = cyc;
                    if (e == STALL && sc[i] < cmax[i]) sc[i]++;
                    if (e[3:2] == 2'b00 && fc[i] < cmax[i]) fc[i]++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic look(input string name, input logic [4:0] e0, input logic [4:0] e1);
        @(negedge clk); #1;
        chk({name, "_dut0"}, o0, e0);
        chk({name, "_dut1"}, o1, e1);
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_branch = 0; id_md_read = 0; pc_src = 0; ex_mem_read = 0;
        ex_branch_resolved = 0; md_start = 0;
    endtask

    initial begin
        idle();
        repeat (2) tick();
        look("reset", DRAIN, DRAIN);
        chk("reset_busy", busy0, 0);

        tick(); reset_n = 1; look("idle", RUNW, RUNW);

        // load-use on rs=5
        tick(); ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 1;
        look("lu0", STALL, STALL);
        tick(); idle(); look("lu1", RUNW, STALL);
        tick(); look("lu2", RUNW, STALL);
        tick(); look("lu3", RUNW, RUNW);

        // register 0 never stalls
        tick(); ex_mem_read = 1; id_uses_rs = 1; look("r0", RUNW, RUNW);

        // branch resolved two cycles later
        tick(); idle(); id_branch = 1; look("br0", BR0, BR0);
        tick(); id_branch = 0; look("br1", DRAIN, DRAIN);
        tick(); ex_branch_resolved = 1; look("br2", BRRES, BRRES);
        tick(); ex_branch_resolved = 0; look("br3", RUNW, RUNW);
`ifdef HAZARD_PERF_EN
        chk("perf_stall_lb3", sc1, 3);
        chk("perf_flush_lb3", fc1, 3);
        chk("perf_stall_lb1", sc0, 1);
`endif

        // jump in ID
        tick(); pc_src = 2'b10; look("jmp", JMP, JMP);
        tick(); pc_src = 0;

        // mult/div: start at cycle 0, read HI/LO from cycle 1, restart at cycle 4
        md_start = 1; look("md0", RUNW, RUNW);
        tick(); md_start = 0; id_md_read = 1; look("md1", STALL, STALL);
        chk("md1_busy", busy0, 1);
        for (int c = 2; c <= 13; c++) begin
            tick();
            md_start = (c == 4);
            if (c == 12) look("md12", STALL, RUNW);
            if (c == 13) look("md13", RUNW, RUNW);
        end
        tick(); idle();

        // load-use together with branch and jump
        tick(); ex_mem_read = 1; ex_rt = 5; id_rs = 5; id_uses_rs = 1;
        id_branch = 1; pc_src = 2'b01;
        look("pri0", STALL, STALL);
        tick(); ex_mem_read = 0; look("pri1", BR0, STALL);
        tick(); look("pri2", DRAIN, STALL);
        tick(); look("pri3", DRAIN, BR0);

        // reset during branch wait
        tick(); idle(); reset_n = 0; look("rst_brwait", DRAIN, DRAIN);
        tick(); reset_n = 1; look("rst_release", RUNW, RUNW);

        // randomized traffic, checked by the model every cycle
        for (int n = 0; n < 4000; n++) begin
            tick();
            id_rs              = 5'($urandom_range(0, 3));
            id_rt              = 5'($urandom_range(0, 3));
            ex_rt              = 5'($urandom_range(0, 3));
            id_uses_rs         = ($urandom_range(0, 99) < 50);
            id_uses_rt         = ($urandom_range(0, 99) < 50);
            ex_mem_read        = ($urandom_range(0, 99) < 30);
            id_branch          = ($urandom_range(0, 99) < 12);
            id_md_read         = ($urandom_range(0, 99) < 30);
            pc_src             = ($urandom_range(0, 99) < 70) ? 2'b00 : 2'($urandom_range(1, 3));
            ex_branch_resolved = ($urandom_range(0, 99) < 30);
            md_start           = ($urandom_range(0, 99) < 6);
            reset_n            = ($urandom_range(0, 999) >= 8);
        end
        tick(); idle(); reset_n = 1;
        repeat (2) tick();
        @(negedge clk); #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
